// File: rtl/usb3_fifo_rd_ctrl_if.sv
// usb3_fifo_rd_ctrl_if: FX3 slave-FIFO read-side pins
interface usb3_fifo_rd_ctrl_if;
    logic       USB3_FLAGA;
    logic       USB3_SLCS_N;
    logic       USB3_SLOE_N;
    logic       USB3_SLRD_N;
    logic [1:0] USB3_A;

    modport master (
        input  USB3_FLAGA,
        output USB3_SLCS_N, USB3_SLOE_N, USB3_SLRD_N, USB3_A
    );

    modport slave (
        output USB3_FLAGA,
        input  USB3_SLCS_N, USB3_SLOE_N, USB3_SLRD_N, USB3_A
    );
endinterface

// File: rtl/usb3_fifo_rd_ctrl.sv
// usb3_fifo_rd_ctrl: sequences FX3 slave-FIFO read bursts into one cache page
module usb3_fifo_rd_ctrl #(
    parameter int         BURST_LEN   = 256,
    parameter int         READ_LAT    = 2,
    parameter int         TAIL_CYC    = 2,
    parameter int         GAP_CYC     = 4,
    parameter logic [1:0] SOCKET_ADDR = 2'd0
) (
    input  logic                      usbclock,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      cache_ready,
    usb3_fifo_rd_ctrl_if.master       fx3,
    output logic [3:0]                usb_rd_state,
    output logic                      burst_done,
    output logic [15:0]               burst_count
);
    localparam int W  = $clog2(BURST_LEN) + 1;
    localparam int SW = $clog2(TAIL_CYC + READ_LAT) + 1;
    localparam int GW = $clog2(GAP_CYC + 1) + 1;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SELECT   = 4'd1,
        OE_ON    = 4'd2,
        RD_START = 4'd3,
        LATENCY  = 4'd4,
        DATA     = 4'd6,
        TAIL     = 4'd7
    } state_t;

    state_t         state, ns;
    logic [W-1:0]   issue_cnt, issue_nx, data_cnt, data_nx;
    logic [SW-1:0]  step_cnt, step_nx;
    logic [GW-1:0]  gap_cnt, gap_dec, gap_nx;
    logic           full, full_nx, rd_nx, done_nx, flaga;

    assign flaga        = fx3.USB3_FLAGA;
    assign usb_rd_state = state;

    // next state plus counter updates; outputs are registered from the next state
    always_comb begin
        ns      = TAIL;
        gap_dec = (gap_cnt != '0) ? gap_cnt - GW'(1) : gap_cnt;
        case (state)
            IDLE:     ns = (enable && cache_ready && flaga && gap_dec == '0) ? SELECT : IDLE;
            SELECT:   ns = flaga ? OE_ON : TAIL;
            OE_ON:    ns = flaga ? RD_START : TAIL;
            RD_START: ns = !flaga ? TAIL : (READ_LAT > 1 ? LATENCY : DATA);
            LATENCY:  ns = !flaga ? TAIL : (step_cnt == SW'(READ_LAT - 1) ? DATA : LATENCY);
            DATA:     ns = (data_cnt == W'(BURST_LEN - 1)) ? TAIL : DATA;
            TAIL:     ns = (step_cnt == SW'(TAIL_CYC)) ? IDLE : TAIL;
            default:  ns = TAIL;
        endcase
        gap_nx   = (ns == IDLE && state != IDLE) ? GW'(GAP_CYC) : gap_dec;
        step_nx  = (ns == LATENCY || ns == TAIL) ? ((ns != state) ? SW'(1) : step_cnt + SW'(1)) : '0;
        data_nx  = (ns == DATA && state == DATA) ? data_cnt + W'(1) : '0;
        rd_nx    = (ns == RD_START) || ((ns == LATENCY || ns == DATA) && issue_cnt < W'(BURST_LEN));
        issue_nx = (ns == IDLE) ? '0 : (ns == RD_START) ? W'(1) : issue_cnt + W'(rd_nx);
        full_nx  = (ns == IDLE) ? 1'b0 : (state == DATA && ns == TAIL) ? 1'b1 : full;
        done_nx  = (state == TAIL) && (ns == IDLE) && full;
    end

    // state, counters and every output pin, released together on reset
    always_ff @(posedge usbclock or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            issue_cnt       <= '0;
            data_cnt        <= '0;
            step_cnt        <= '0;
            gap_cnt         <= '0;
            full            <= 1'b0;
            fx3.USB3_SLCS_N <= 1'b1;
            fx3.USB3_SLOE_N <= 1'b1;
            fx3.USB3_SLRD_N <= 1'b1;
            fx3.USB3_A      <= 2'd0;
            burst_done      <= 1'b0;
            burst_count     <= '0;
        end else begin
            state           <= ns;
            issue_cnt       <= issue_nx;
            data_cnt        <= data_nx;
            step_cnt        <= step_nx;
            gap_cnt         <= gap_nx;
            full            <= full_nx;
            fx3.USB3_SLCS_N <= (ns == IDLE);
            fx3.USB3_SLOE_N <= (ns == IDLE) || (ns == SELECT);
            fx3.USB3_SLRD_N <= !rd_nx;
            fx3.USB3_A      <= (ns == IDLE) ? 2'd0 : SOCKET_ADDR;
            burst_done      <= done_nx;
            burst_count     <= burst_count + 16'(done_nx);
        end
    end
endmodule

// File: tb/tb_usb3_fifo_rd_ctrl.sv
// tb_usb3_fifo_rd_ctrl: directed checks of burst sequencing, gap, abort, hold and reset
module tb_usb3_fifo_rd_ctrl;
    logic        usbclock, rst_n, rst_b, enable, cache_ready, flaga, sel;
    logic [3:0]  st_a, st_b, st;
    logic        done_a, done_b, done;
    logic [15:0] cnt_a, cnt_b, cnt;
    logic        slcs_n, sloe_n, slrd_n;
    logic [1:0]  addr;
    int          n_chk, n_fail;

    usb3_fifo_rd_ctrl_if fx_a ();
    usb3_fifo_rd_ctrl_if fx_b ();
    assign fx_a.USB3_FLAGA = flaga;
    assign fx_b.USB3_FLAGA = flaga;

    usb3_fifo_rd_ctrl dut_a (
        .usbclock(usbclock), .rst_n(rst_n), .enable(enable), .cache_ready(cache_ready),
        .fx3(fx_a), .usb_rd_state(st_a), .burst_done(done_a), .burst_count(cnt_a)
    );

    usb3_fifo_rd_ctrl #(.BURST_LEN(4), .READ_LAT(1), .SOCKET_ADDR(2'd2)) dut_b (
        .usbclock(usbclock), .rst_n(rst_b), .enable(enable), .cache_ready(cache_ready),
        .fx3(fx_b), .usb_rd_state(st_b), .burst_done(done_b), .burst_count(cnt_b)
    );

    assign st     = sel ? st_b : st_a;
    assign done   = sel ? done_b : done_a;
    assign cnt    = sel ? cnt_b : cnt_a;
    assign slcs_n = sel ? fx_b.USB3_SLCS_N : fx_a.USB3_SLCS_N;
    assign sloe_n = sel ? fx_b.USB3_SLOE_N : fx_a.USB3_SLOE_N;
    assign slrd_n = sel ? fx_b.USB3_SLRD_N : fx_a.USB3_SLRD_N;
    assign addr   = sel ? fx_b.USB3_A : fx_a.USB3_A;

    initial usbclock = 1'b0;
    always #5 usbclock = ~usbclock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, st, 0);
        chk({tag, "_slcs"}, slcs_n, 1);
        chk({tag, "_sloe"}, sloe_n, 1);
        chk({tag, "_slrd"}, slrd_n, 1);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_count"}, cnt, 0);
    endtask

    // follows one burst from its first SELECT cycle to its first IDLE cycle
    task automatic run_burst(input int bl, input int lat, input logic [1:0] sock, input string tag);
        int n, e, seq_err, low, rise, dcnt, dones;
        logic [1:0] a0;
        n = 0;
        while (st != 4'd1 && n < 100) begin
            @(negedge usbclock);
            n++;
        end
        chk({tag, "_start"}, st, 1);
        seq_err = 0; low = 0; rise = -1; dcnt = 0; dones = 0; a0 = addr;
        for (int i = 0; i < bl + lat + 5; i++) begin
            e = i < 3 ? i + 1 : i < lat + 2 ? 4 : i < lat + 2 + bl ? 6 : i < lat + 4 + bl ? 7 : 0;
            if (st != 4'(e)) seq_err++;
            if (slcs_n != (e == 0)) seq_err++;
            if (sloe_n != (e == 0 || e == 1)) seq_err++;
            if (!slrd_n) low++;
            if (st == 4'd6) begin
                if (slrd_n && rise < 0) rise = dcnt;
                dcnt++;
            end
            if (done) dones++;
            if (i < bl + lat + 4) @(negedge usbclock);
        end
        chk({tag, "_seq"}, seq_err, 0);
        chk({tag, "_addr"}, a0, sock);
        chk({tag, "_rd_low"}, low, bl);
        chk({tag, "_rd_rise"}, rise, bl - lat);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_done_end"}, done, 1);
    endtask

    initial begin
        int n, err;
        n_chk = 0; n_fail = 0;
        rst_n = 0; rst_b = 0; enable = 0; cache_ready = 0; flaga = 0; sel = 0;
        repeat (3) @(negedge usbclock);
        chk_reset("rst");
        rst_n = 1; enable = 1; cache_ready = 1; flaga = 1;
        run_burst(256, 2, 2'd0, "t1");
        chk("t1_count", cnt, 1);
        for (int b = 2; b <= 3; b++) begin
            n = 0;
            while (st == 4'd0 && n < 50) begin
                n++;
                @(negedge usbclock);
            end
            chk("t2_gap", n, 4);
            run_burst(256, 2, 2'd0, "t2");
            chk("t2_count", cnt, b);
        end
        n = 0;
        while (st != 4'd2 && n < 50) begin
            @(negedge usbclock);
            n++;
        end
        chk("t3_in_oe", st, 2);
        flaga = 0;
        @(negedge usbclock);
        flaga = 1;
        chk("t3_abort", st, 7);
        chk("t3_done0", done, 0);
        @(negedge usbclock);
        chk("t3_tail", st, 7);
        @(negedge usbclock);
        chk("t3_idle", st, 0);
        chk("t3_done1", done, 0);
        chk("t3_count", cnt, 3);
        cache_ready = 0;
        err = 0;
        repeat (10) begin
            @(negedge usbclock);
            if (st != 4'd0 || !slcs_n || !sloe_n || !slrd_n) err++;
        end
        chk("t4_hold", err, 0);
        cache_ready = 1;
        @(negedge usbclock);
        chk("t4_go", st, 1);
        n = 0;
        while (st != 4'd6 && n < 20) begin
            @(negedge usbclock);
            n++;
        end
        repeat (100) @(negedge usbclock);
        chk("t5_in_data", st, 6);
        chk("t5_rd_low", slrd_n, 0);
        rst_n = 0;
        #1;
        chk_reset("t5_rst");
        @(negedge usbclock);
        rst_n = 1;
        run_burst(256, 2, 2'd0, "t5");
        chk("t5_count", cnt, 1);
        sel = 1;
        rst_b = 1;
        run_burst(4, 1, 2'd2, "t6");
        chk("t6_count", cnt, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
